// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state encoding
package uart_pkg;

  localparam int CNT_MAX_DEF = 5208;
  localparam int DATA_W      = 8;
  localparam int FRAME_BITS  = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - 0..CNT_MAX-1 bit-period counter with end-of-bit pulse
module uart_baud_cnt #(
  parameter int CNT_MAX = 5208,
  parameter int CW      = $clog2(CNT_MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic end_bit
);

  logic [CW-1:0] cnt;

  assign end_bit = en && (cnt == CW'(CNT_MAX - 1));

  // Held at zero while disabled so the first bit after enable is a full period.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (end_bit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-entry holding register
module uart_tx
  import uart_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              rdy,
  output logic              busy,
  output logic              dout
);

  logic [1:0]        state;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] hold;
  logic [2:0]        bit_cnt;
  logic              end_bit;
  logic              accept;
  logic              stop_end;

  assign accept   = din_vld && rdy;
  assign stop_end = (state == ST_STOP) && end_bit;

  uart_baud_cnt #(.CNT_MAX(CNT_MAX)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != ST_IDLE),
    .end_bit (end_bit)
  );

  // rdy doubles as the hold-empty flag: hold is full exactly when rdy=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shifter <= '0;
      hold    <= '0;
      bit_cnt <= '0;
      dout    <= 1'b1;
      rdy     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      if (accept && (state != ST_IDLE) && !stop_end) begin
        hold <= din;
        rdy  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shifter <= din;
            state   <= ST_START;
            dout    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (end_bit) begin
            dout    <= shifter[0];
            shifter <= shifter >> 1;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (end_bit) begin
            if (bit_cnt == 3'd7) begin
              dout  <= 1'b1;
              state <= ST_STOP;
            end else begin
              dout    <= shifter[0];
              shifter <= shifter >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (end_bit) begin
            // Queued or same-cycle byte chains straight into a new start bit.
            if (!rdy) begin
              shifter <= hold;
              hold    <= '0;
              rdy     <= 1'b1;
              state   <= ST_START;
              dout    <= 1'b0;
            end else if (accept) begin
              shifter <= din;
              state   <= ST_START;
              dout    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a serial-decoding monitor
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CNT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic       rdy;
  logic       busy;
  logic       dout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_frames = 0;
  bit rx_active = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  always #20 clk = ~clk;

  uart_tx #(.CNT_MAX(CNT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .rdy     (rdy),
    .busy    (busy),
    .dout    (dout)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Receiver model: finds the start bit, samples mid-bit, pops the scoreboard on the stop bit.
  initial begin
    int rc;
    logic [7:0] rb;
    rc = 0;
    rb = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_active = 0;
      end else if (!rx_active) begin
        if (dout === 1'b0) begin
          rx_active = 1;
          rc = 0;
          start_cyc.push_back(cyc);
        end
      end else begin
        rc++;
        if (rc == 4) begin
          chk("rx_start_bit", int'(dout), 0);
        end else if (rc >= 14 && rc <= 84 && (rc - 14) % 10 == 0) begin
          rb[(rc - 14) / 10] = dout;
        end else if (rc == 94) begin
          chk("rx_stop_bit", int'(dout), 1);
          rx_frames++;
          rx_active = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected_byte: got 0x%02h expected no frame", rb);
          end else begin
            chk("rx_byte", int'(rb), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output int acc_cyc);
    @(negedge clk);
    din = b;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    din_vld = 1'b0;
    din = ~b;
  endtask

  task automatic wait_rdy();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_rdy_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && !rx_active) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    #(40 * 40000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, dummy, bc, s_base, rdy_cyc, zeros;
    logic [9:0] frame35;
    logic [7:0] loop_bytes[3];
    frame35 = {1'b1, 8'h35, 1'b0};
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h55;

    // Reset with din_vld asserted
    din = 8'h35;
    din_vld = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dout", int'(dout), 1);
    chk("reset_rdy", int'(rdy), 1);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    din_vld = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_dout", int'(dout), 1);
    chk("post_reset_no_start", start_cyc.size(), 0);

    // Single byte 0x35: bit levels, latency and busy length
    exp_q.push_back(8'h35);
    send(8'h35, a1);
    bc = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (n == 0) chk("start_latency", int'(dout), 0);
      if (!busy) break;
      bc++;
      if (n % 10 == 5 && n < 100) chk("frame35_level", int'(dout), int'(frame35[n / 10]));
    end
    chk("busy_len", bc, FRAME_BITS * CNT);
    wait_idle();
    chk("single_q_empty", exp_q.size(), 0);

    // Back-to-back 0xA5 / 0x5A with 0xFF overflow attempt
    s_base = start_cyc.size();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    send(8'hA5, a1);
    repeat (19) @(negedge clk);
    send(8'h5A, a2);
    @(negedge clk);
    chk("rdy_low_after_hold", int'(rdy), 0);
    send(8'hFF, dummy);
    @(negedge clk);
    chk("rdy_low_after_overflow", int'(rdy), 0);
    rdy_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (rdy) begin
        rdy_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    wait_idle();
    if (start_cyc.size() >= s_base + 2) begin
      chk("first_start_cycle", start_cyc[s_base], a1);
      chk("b2b_gap", start_cyc[s_base + 1] - start_cyc[s_base], FRAME_BITS * CNT);
      chk("rdy_rise_at_start", rdy_cyc, start_cyc[s_base + 1]);
    end else begin
      chk("b2b_frame_starts", start_cyc.size() - s_base, 2);
    end
    chk("b2b_q_empty", exp_q.size(), 0);
    chk("b2b_frames", rx_frames, 3);

    // Reset during data bit 3 of 0x0F with 0xF0 queued
    send(8'h0F, a1);
    send(8'hF0, dummy);
    for (int i = 0; i < 100 && cyc < a1 + 44; i++) @(negedge clk);
    chk("bit3_level", int'(dout), 1);
    chk("queued_rdy_low", int'(rdy), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_dout", int'(dout), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_rdy", int'(rdy), 1);
    rst_n = 1'b1;
    zeros = 0;
    repeat (250) begin
      @(negedge clk);
      if (dout !== 1'b1 || busy !== 1'b0) zeros++;
    end
    chk("no_tx_after_reset", zeros, 0);

    // Loopback-style decode of 0x00, 0xFF, 0x55
    for (int k = 0; k < 3; k++) begin
      wait_rdy();
      exp_q.push_back(loop_bytes[k]);
      send(loop_bytes[k], dummy);
    end
    wait_idle();
    chk("loop_q_empty", exp_q.size(), 0);
    chk("total_frames", rx_frames, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
